serializer: RTL and testbench

Parallel-to-serial stage for the parallel datapath. Accepts one bundle of `N_SAMPLES` words on a val/rdy receive interface, registers it, and emits the words one per handshake on a single-word val/rdy send interface. It sits directly downstream of the deserializer control stage, and its output has the same word order as that stage's input. This restores a sample stream after parallel processing.

---
 rtl/serializer_pkg.sv | 14 +
 rtl/serializer_ctrl.sv | 65 ++++++
 rtl/serializer.sv | 57 +++++
 tb/tb_serializer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial stage.
package serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Width of the word counter; at least one bit even for single-word bundles.
  function automatic int unsigned count_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serializer_ctrl.sv
// Control FSM for the serializer: handshake outputs, capture enable, word select.
module serializer_ctrl
  import serializer_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 8,
  parameter int unsigned CNT_W     = count_width(N_SAMPLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             recv_val,
  output logic             recv_rdy,
  output logic             send_val,
  input  logic             send_rdy,
  output logic             capture,
  output logic [CNT_W-1:0] sel
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  state_e           state;
  state_e           state_next;
  logic [CNT_W-1:0] count;
  logic             last_beat;

  assign last_beat = send_val && send_rdy && (count == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept a bundle in IDLE, leave SEND after the last beat.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture)   state_next = SEND;
      SEND:    if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs depend only on registered state, with reset forcing both handshakes low.
  always_comb begin
    recv_rdy = (state == IDLE) && !reset;
    send_val = (state == SEND) && !reset;
    capture  = recv_val && recv_rdy;
    sel      = count;
  end

  // Word counter: cleared on capture and after the last beat, advances per send beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (capture || last_beat) begin
      count <= '0;
    end else if (send_val && send_rdy) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial stage: registers one bundle and emits its words in order.
module serializer
  import serializer_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned N_SAMPLES = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_SAMPLES*BIT_WIDTH-1:0] recv_msg,
  input  logic                           recv_val,
  output logic                           recv_rdy,
  output logic [BIT_WIDTH-1:0]           send_msg,
  output logic                           send_val,
  input  logic                           send_rdy
);

  localparam int unsigned CNT_W = count_width(N_SAMPLES);

  logic [N_SAMPLES*BIT_WIDTH-1:0] bundle;
  logic                           capture;
  logic [CNT_W-1:0]               sel;
  logic [BIT_WIDTH-1:0]           word;

  serializer_ctrl #(
    .N_SAMPLES (N_SAMPLES),
    .CNT_W     (CNT_W)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .capture  (capture),
    .sel      (sel)
  );

  // Bundle register: loads only on an accepted receive transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      bundle <= '0;
    end else if (capture) begin
      bundle <= recv_msg;
    end
  end

  // Word mux: selected word while sending, zero otherwise.
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < N_SAMPLES; i++) begin
      if (sel == CNT_W'(i)) word = bundle[i*BIT_WIDTH +: BIT_WIDTH];
    end
    send_msg = send_val ? word : '0;
  end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench: two serializer configurations against a queue-based model.
module tb_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N_SAMPLES=4, BIT_WIDTH=8
  logic        a_reset, a_recv_val, a_recv_rdy, a_send_val, a_send_rdy;
  logic [31:0] a_recv_msg;
  logic [7:0]  a_send_msg;

  // Instance B: N_SAMPLES=1, BIT_WIDTH=16
  logic        b_reset, b_recv_val, b_recv_rdy, b_send_val, b_send_rdy;
  logic [15:0] b_recv_msg;
  logic [15:0] b_send_msg;

  serializer #(.BIT_WIDTH(8), .N_SAMPLES(4)) dut_a (
    .clk(clk), .reset(a_reset), .recv_msg(a_recv_msg), .recv_val(a_recv_val),
    .recv_rdy(a_recv_rdy), .send_msg(a_send_msg), .send_val(a_send_val),
    .send_rdy(a_send_rdy)
  );

  serializer #(.BIT_WIDTH(16), .N_SAMPLES(1)) dut_b (
    .clk(clk), .reset(b_reset), .recv_msg(b_recv_msg), .recv_val(b_recv_val),
    .recv_rdy(b_recv_rdy), .send_msg(b_send_msg), .send_val(b_send_val),
    .send_rdy(b_send_rdy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bundle becomes a queue of pending words; the stage is
  // idle exactly when nothing is pending. Reset drops everything pending.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  bit a_seen = 0, b_seen = 0;

  always @(posedge clk) begin
    if (a_reset) begin
      qa.delete();
      a_seen = 1;
    end else if (qa.size() == 0) begin
      if (a_recv_val) for (int i = 0; i < 4; i++) qa.push_back(32'(a_recv_msg[i*8 +: 8]));
    end else if (a_send_rdy) begin
      void'(qa.pop_front());
    end

    if (b_reset) begin
      qb.delete();
      b_seen = 1;
    end else if (qb.size() == 0) begin
      if (b_recv_val) qb.push_back(32'(b_recv_msg));
    end else if (b_send_rdy) begin
      void'(qb.pop_front());
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (a_seen) begin
      chk("a.recv_rdy", 32'(a_recv_rdy), 32'(!a_reset && qa.size() == 0));
      chk("a.send_val", 32'(a_send_val), 32'(!a_reset && qa.size() != 0));
      if (!a_reset) chk("a.send_msg", 32'(a_send_msg), (qa.size() != 0) ? qa[0] : 32'h0);
    end
    if (b_seen) begin
      chk("b.recv_rdy", 32'(b_recv_rdy), 32'(!b_reset && qb.size() == 0));
      chk("b.send_val", 32'(b_send_val), 32'(!b_reset && qb.size() != 0));
      if (!b_reset) chk("b.send_msg", 32'(b_send_msg), (qb.size() != 0) ? qb[0] : 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] msg, input logic val, input logic rdy);
    chk({tag, ".msg"}, 32'(a_send_msg), 32'(msg));
    chk({tag, ".val"}, 32'(a_send_val), 32'(val));
    chk({tag, ".rdy"}, 32'(a_recv_rdy), 32'(rdy));
  endtask

  task automatic accept_a(input logic [31:0] msg);
    a_recv_val = 1'b1;
    a_recv_msg = msg;
    step();
    a_recv_val = 1'b0;
  endtask

  initial begin
    a_reset = 1'b1; a_recv_val = 1'b1; a_recv_msg = 32'hA5A5A5A5; a_send_rdy = 1'b1;
    b_reset = 1'b1; b_recv_val = 1'b1; b_recv_msg = 16'h5A5A;     b_send_rdy = 1'b1;

    // Reset held two cycles with recv_val asserted.
    step(); chk_a("rst1", 8'h00, 1'b0, 1'b0);
    chk("rst1.b.rdy", 32'(b_recv_rdy), 32'h0);
    step(); chk_a("rst2", 8'h00, 1'b0, 1'b0);
    chk("rst2.b.val", 32'(b_send_val), 32'h0);
    a_reset = 1'b0; a_recv_val = 1'b0;
    b_reset = 1'b0; b_recv_val = 1'b0;
    #1; chk_a("post_rst", 8'h00, 1'b0, 1'b1);

    // Basic stream.
    accept_a(32'h44332211);
    chk_a("basic1", 8'h11, 1'b1, 1'b0);
    step(); chk_a("basic2", 8'h22, 1'b1, 1'b0);
    step(); chk_a("basic3", 8'h33, 1'b1, 1'b0);
    step(); chk_a("basic4", 8'h44, 1'b1, 1'b0);
    step(); chk_a("basic5", 8'h00, 1'b0, 1'b1);

    // Backpressure during word 0x22.
    accept_a(32'h44332211);
    step(); chk_a("bp_22", 8'h22, 1'b1, 1'b0);
    a_send_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_a("bp_hold", 8'h22, 1'b1, 1'b0);
    end
    a_send_rdy = 1'b1;
    step(); chk_a("bp_33", 8'h33, 1'b1, 1'b0);
    step(); chk_a("bp_44", 8'h44, 1'b1, 1'b0);
    step(); chk_a("bp_idle", 8'h00, 1'b0, 1'b1);

    // Receive side ignored while sending.
    accept_a(32'h44332211);
    a_recv_val = 1'b1; a_recv_msg = 32'hDEADBEEF;
    step(); chk_a("ign_22", 8'h22, 1'b1, 1'b0);
    step(); chk_a("ign_33", 8'h33, 1'b1, 1'b0);
    a_recv_val = 1'b0;
    step(); chk_a("ign_44", 8'h44, 1'b1, 1'b0);
    step(); chk_a("ign_idle", 8'h00, 1'b0, 1'b1);

    // Reset after two words sent, then a fresh bundle.
    accept_a(32'h44332211);
    step(); step(); chk_a("mid_33", 8'h33, 1'b1, 1'b0);
    a_reset = 1'b1;
    #1; chk("mid_rst.val", 32'(a_send_val), 32'h0);
    chk("mid_rst.rdy", 32'(a_recv_rdy), 32'h0);
    step(); a_reset = 1'b0;
    #1; chk_a("mid_idle", 8'h00, 1'b0, 1'b1);
    accept_a(32'hDDCCBBAA);
    chk_a("new_aa", 8'hAA, 1'b1, 1'b0);
    step(); chk_a("new_bb", 8'hBB, 1'b1, 1'b0);
    step(); chk_a("new_cc", 8'hCC, 1'b1, 1'b0);
    step(); chk_a("new_dd", 8'hDD, 1'b1, 1'b0);
    step(); chk_a("new_idle", 8'h00, 1'b0, 1'b1);

    // Single-word bundles, back to back.
    b_recv_val = 1'b1; b_recv_msg = 16'hBEEF;
    step();
    chk("n1_beat.msg", 32'(b_send_msg), 32'h0000BEEF);
    chk("n1_beat.rdy", 32'(b_recv_rdy), 32'h0);
    step();
    chk("n1_idle.val", 32'(b_send_val), 32'h0);
    chk("n1_idle.rdy", 32'(b_recv_rdy), 32'h1);
    b_recv_msg = 16'h1234;
    step();
    chk("n1_b2b.msg", 32'(b_send_msg), 32'h00001234);
    chk("n1_b2b.val", 32'(b_send_val), 32'h1);
    b_recv_val = 1'b0;
    step();

    // Randomized traffic on both instances, with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      a_recv_val = ($urandom_range(0, 3) != 0);
      a_recv_msg = $urandom;
      a_send_rdy = ($urandom_range(0, 9) < 7);
      a_reset    = ($urandom_range(0, 63) == 0);
      b_recv_val = ($urandom_range(0, 1) != 0);
      b_recv_msg = 16'($urandom);
      b_send_rdy = ($urandom_range(0, 9) < 6);
      b_reset    = ($urandom_range(0, 63) == 0);
      step();
    end
    a_reset = 1'b0; b_reset = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
